// File: rtl/data_bus_arbiter_if.sv
// Ibex-style data bus: request/grant channel plus in-order response channel.
// The master modport issues requests and the slave modport answers them.
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, rdata_intg, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, rdata_intg, err
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Merges the core LSU (master 0) and an auxiliary master (1) onto one data bus.
// Responses are routed back through an in-order ID FIFO. Define
// DATA_BUS_ARB_ROUND_ROBIN_EN for round-robin conflicts; default is core priority.
module data_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ibex_data_bus.slave  core_bus,
  ibex_data_bus.slave  aux_bus,
  ibex_data_bus.master mem_bus,
  output logic        resp_orphan
);

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_AUX  = 1'b1
  } mst_e;

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  mst_e          fifo_q [MAX_OUTSTANDING];
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          orphan_q, orphan_d;

  logic full, sel_valid, sel_aux, push, pop;
  mst_e sel_id, conflict_win, head_id;

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  mst_e last_q, last_d;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A pop in this cycle frees a slot, so a full FIFO still accepts a request
  // when rvalid is present; this sustains one transfer per cycle at depth 1.
  always_comb begin
    full = (count_q == CNT_MAX) && !mem_bus.rvalid;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    conflict_win = (last_q == MST_AUX) ? MST_CORE : MST_AUX;
`else
    conflict_win = MST_CORE;
`endif
    if (core_bus.req && aux_bus.req) begin
      sel_id = conflict_win;
    end else if (aux_bus.req) begin
      sel_id = MST_AUX;
    end else begin
      sel_id = MST_CORE;
    end
    sel_valid = (core_bus.req || aux_bus.req) && !full;
    sel_aux   = sel_valid && (sel_id == MST_AUX);
  end

  assign mem_bus.req   = sel_valid;
  assign mem_bus.we    = sel_aux ? aux_bus.we    : core_bus.we;
  assign mem_bus.be    = sel_aux ? aux_bus.be    : core_bus.be;
  assign mem_bus.addr  = sel_aux ? aux_bus.addr  : core_bus.addr;
  assign mem_bus.wdata = sel_aux ? aux_bus.wdata : core_bus.wdata;

  assign core_bus.gnt = sel_valid && (sel_id == MST_CORE) && mem_bus.gnt;
  assign aux_bus.gnt  = sel_aux && mem_bus.gnt;

  assign push    = sel_valid && mem_bus.gnt;
  assign pop     = mem_bus.rvalid && (count_q != '0);
  assign head_id = fifo_q[rptr_q];

  assign core_bus.rvalid     = pop && (head_id == MST_CORE);
  assign aux_bus.rvalid      = pop && (head_id == MST_AUX);
  assign core_bus.rdata      = mem_bus.rdata;
  assign aux_bus.rdata       = mem_bus.rdata;
  assign core_bus.rdata_intg = mem_bus.rdata_intg;
  assign aux_bus.rdata_intg  = mem_bus.rdata_intg;
  assign core_bus.err        = mem_bus.err;
  assign aux_bus.err         = mem_bus.err;

  assign resp_orphan = orphan_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wptr_d   = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d   = pop  ? ptr_inc(rptr_q) : rptr_q;
    orphan_d = orphan_q || (mem_bus.rvalid && (count_q == '0));
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    last_d = push ? sel_id : last_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      orphan_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= MST_CORE;
      end
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
      last_q <= MST_AUX;
`endif
    end else begin
      count_q  <= count_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      orphan_q <= orphan_d;
      if (push) begin
        fifo_q[wptr_q] <= sel_id;
      end
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
      last_q <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: two instances (depth 2 and depth 1) behind bench RAM
// slaves with selectable response latency, checked each cycle against a queue model.
module tb_data_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ibex_data_bus c2 ();
  ibex_data_bus a2 ();
  ibex_data_bus m2 ();
  ibex_data_bus c1 ();
  ibex_data_bus a1 ();
  ibex_data_bus m1 ();
  logic orph2_o, orph1_o;

  data_bus_arbiter #(.MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .core_bus(c2), .aux_bus(a2), .mem_bus(m2), .resp_orphan(orph2_o)
  );
  data_bus_arbiter #(.MAX_OUTSTANDING(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .core_bus(c1), .aux_bus(a1), .mem_bus(m1), .resp_orphan(orph1_o)
  );

  // ---------------- bench RAM slaves: gnt = req, rvalid lat cycles later ----------------
  int lat2 = 1;
  int lat1 = 1;
  bit inj2 = 1'b0;
  bit        pv2 [3];
  bit [31:0] pd2 [3];
  bit [6:0]  pi2 [3];
  bit        pe2 [3];
  bit        pv1 [3];
  bit [31:0] pd1 [3];
  bit [6:0]  pi1 [3];
  bit        pe1 [3];
  bit [31:0] wr_data [512];
  bit        wr_valid [512];

  function automatic bit [31:0] ram_rd(input logic [31:0] a);
    if (wr_valid[a[10:2]]) return wr_data[a[10:2]];
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign m2.gnt        = m2.req;
  assign m2.rvalid     = pv2[lat2-1] | inj2;
  assign m2.rdata      = pd2[lat2-1];
  assign m2.rdata_intg = pi2[lat2-1];
  assign m2.err        = pe2[lat2-1];
  assign m1.gnt        = m1.req;
  assign m1.rvalid     = pv1[lat1-1];
  assign m1.rdata      = pd1[lat1-1];
  assign m1.rdata_intg = pi1[lat1-1];
  assign m1.err        = pe1[lat1-1];

  always @(posedge clk) begin
    pv2[0] <= m2.req && m2.gnt;
    pd2[0] <= m2.we ? 32'h0 : ram_rd(m2.addr);
    pi2[0] <= (m2.we ? 7'h0 : ram_rd(m2.addr) & 32'h7F) ^ 7'h2A;
    pe2[0] <= m2.addr[28];
    pv1[0] <= m1.req && m1.gnt;
    pd1[0] <= m1.we ? 32'h0 : ram_rd(m1.addr);
    pi1[0] <= (m1.we ? 7'h0 : ram_rd(m1.addr) & 32'h7F) ^ 7'h2A;
    pe1[0] <= m1.addr[28];
    for (int k = 1; k < 3; k++) begin
      pv2[k] <= pv2[k-1]; pd2[k] <= pd2[k-1]; pi2[k] <= pi2[k-1]; pe2[k] <= pe2[k-1];
      pv1[k] <= pv1[k-1]; pd1[k] <= pd1[k-1]; pi1[k] <= pi1[k-1]; pe1[k] <= pe1[k-1];
    end
    if (m2.req && m2.gnt && m2.we) begin
      wr_data[m2.addr[10:2]]  <= m2.wdata;
      wr_valid[m2.addr[10:2]] <= 1'b1;
    end
    if (m1.req && m1.gnt && m1.we) begin
      wr_data[m1.addr[10:2]]  <= m1.wdata;
      wr_valid[m1.addr[10:2]] <= 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic cr, ar;
    logic cwe; logic [3:0] cbe; logic [31:0] caddr, cwdata;
    logic awe; logic [3:0] abe; logic [31:0] aaddr, awdata;
    logic mg, mrv; logic [31:0] mrdata; logic [6:0] mintg; logic merr;
  } in_t;

  typedef struct packed {
    logic mreq, mwe; logic [3:0] mbe; logic [31:0] maddr, mwdata;
    logic cg, ag, crv, arv;
    logic [31:0] crdata, ardata; logic [6:0] cintg, aintg; logic cerr, aerr;
    logic orph;
  } obs_t;

  // Expected behaviour from the arbitration rules; hs/win feed the model update.
  task automatic cmp_inst(input string tag, input int unsigned max, input int unsigned n,
                          input bit head, input bit last, input bit orph,
                          input in_t i, input obs_t o, output bit hs, output bit win);
    bit full, any, sel, take_aux;
    full = (n == max) && !i.mrv;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    sel = (i.cr && i.ar) ? !last : i.ar;
`else
    sel = (i.cr && i.ar) ? 1'b0 : i.ar;
`endif
    any = (i.cr || i.ar) && !full;
    take_aux = any && sel;
    chk({tag, ".mem_req"},  32'(o.mreq), 32'(any));
    chk({tag, ".mem_we"},   32'(o.mwe),  32'(take_aux ? i.awe : i.cwe));
    chk({tag, ".mem_be"},   32'(o.mbe),  32'(take_aux ? i.abe : i.cbe));
    chk({tag, ".mem_addr"}, o.maddr,     take_aux ? i.aaddr : i.caddr);
    chk({tag, ".mem_wdata"}, o.mwdata,   take_aux ? i.awdata : i.cwdata);
    chk({tag, ".core_gnt"}, 32'(o.cg),   32'(any && !sel && i.mg));
    chk({tag, ".aux_gnt"},  32'(o.ag),   32'(take_aux && i.mg));
    chk({tag, ".core_rvalid"}, 32'(o.crv), 32'(i.mrv && n > 0 && !head));
    chk({tag, ".aux_rvalid"},  32'(o.arv), 32'(i.mrv && n > 0 && head));
    chk({tag, ".core_rdata"}, o.crdata, i.mrdata);
    chk({tag, ".aux_rdata"},  o.ardata, i.mrdata);
    chk({tag, ".core_intg"},  32'(o.cintg), 32'(i.mintg));
    chk({tag, ".aux_intg"},   32'(o.aintg), 32'(i.mintg));
    chk({tag, ".core_err"},   32'(o.cerr), 32'(i.merr));
    chk({tag, ".aux_err"},    32'(o.aerr), 32'(i.merr));
    chk({tag, ".orphan"},     32'(o.orph), 32'(orph));
    hs  = any && i.mg;
    win = sel;
  endtask

  bit q2[$];
  bit q1[$];
  bit last2 = 1'b1, last1 = 1'b1;
  bit orph2 = 1'b0, orph1 = 1'b0;
  in_t  in2, in1;
  obs_t ob2, ob1;
  bit hs2, win2, hs1, win1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete(); q1.delete();
      last2 = 1'b1; last1 = 1'b1; orph2 = 1'b0; orph1 = 1'b0;
    end
    in2 = '{c2.req, a2.req, c2.we, c2.be, c2.addr, c2.wdata, a2.we, a2.be, a2.addr, a2.wdata,
            m2.gnt, m2.rvalid, m2.rdata, m2.rdata_intg, m2.err};
    ob2 = '{m2.req, m2.we, m2.be, m2.addr, m2.wdata, c2.gnt, a2.gnt, c2.rvalid, a2.rvalid,
            c2.rdata, a2.rdata, c2.rdata_intg, a2.rdata_intg, c2.err, a2.err, orph2_o};
    in1 = '{c1.req, a1.req, c1.we, c1.be, c1.addr, c1.wdata, a1.we, a1.be, a1.addr, a1.wdata,
            m1.gnt, m1.rvalid, m1.rdata, m1.rdata_intg, m1.err};
    ob1 = '{m1.req, m1.we, m1.be, m1.addr, m1.wdata, c1.gnt, a1.gnt, c1.rvalid, a1.rvalid,
            c1.rdata, a1.rdata, c1.rdata_intg, a1.rdata_intg, c1.err, a1.err, orph1_o};
    cmp_inst("d2", 2, q2.size(), (q2.size() > 0) ? q2[0] : 1'b0, last2, orph2, in2, ob2, hs2, win2);
    cmp_inst("d1", 1, q1.size(), (q1.size() > 0) ? q1[0] : 1'b0, last1, orph1, in1, ob1, hs1, win1);
    if (rst_n) begin
      if (in2.mrv) begin
        if (q2.size() > 0) void'(q2.pop_front()); else orph2 = 1'b1;
      end
      if (hs2) begin q2.push_back(win2); last2 = win2; end
      if (in1.mrv) begin
        if (q1.size() > 0) void'(q1.pop_front()); else orph1 = 1'b1;
      end
      if (hs1) begin q1.push_back(win1); last1 = win1; end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
  endtask

`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
  int exp_order[4] = '{0, 1, 0, 1};
`else
  int exp_order[4] = '{0, 0, 0, 0};
`endif
  bit exp_g3[7]  = '{1, 1, 0, 1, 1, 0, 1};
  bit exp_rv3[7] = '{0, 0, 0, 1, 1, 0, 1};

  initial begin
    int win;
    c2.req = 0; c2.we = 0; c2.be = 4'hF; c2.addr = '0; c2.wdata = '0;
    a2.req = 0; a2.we = 0; a2.be = 4'hF; a2.addr = '0; a2.wdata = '0;
    c1.req = 0; c1.we = 0; c1.be = 4'hF; c1.addr = '0; c1.wdata = '0;
    a1.req = 0; a1.we = 0; a1.be = 4'hF; a1.addr = '0; a1.wdata = '0;

    // Reset state, with a stray rvalid while reset is held
    tick(); inj2 = 1'b1;
    @(negedge clk);
    chk("rst.core_rvalid", 32'(c2.rvalid), 0);
    chk("rst.aux_rvalid", 32'(a2.rvalid), 0);
    chk("rst.mem_req", 32'(m2.req), 0);
    tick(); inj2 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst.orphan", 32'(orph2_o), 0);

    // Single core read
    tick(); c2.req = 1; c2.addr = 32'h100;
    @(negedge clk);
    chk("t1.core_gnt", 32'(c2.gnt), 1);
    chk("t1.aux_gnt", 32'(a2.gnt), 0);
    tick(); c2.req = 0;
    @(negedge clk);
    chk("t1.core_rvalid", 32'(c2.rvalid), 1);
    chk("t1.core_rdata", c2.rdata, 32'hDEAD_BEEF);
    chk("t1.aux_rvalid", 32'(a2.rvalid), 0);

    // Both masters request for 4 cycles
    do_reset();
    tick(); c2.req = 1; c2.addr = 32'h200; a2.req = 1; a2.addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      win = c2.gnt ? 0 : (a2.gnt ? 1 : 2);
      chk("t2.winner", 32'(win), 32'(exp_order[i]));
      if (i > 0) begin
        chk("t2.core_rvalid", 32'(c2.rvalid), 32'(exp_order[i-1] == 0));
        chk("t2.aux_rvalid", 32'(a2.rvalid), 32'(exp_order[i-1] == 1));
      end
      tick();
    end
    c2.req = 0; a2.req = 0;
    @(negedge clk);
    chk("t2.core_rvalid_last", 32'(c2.rvalid), 32'(exp_order[3] == 0));
    chk("t2.aux_rvalid_last", 32'(a2.rvalid), 32'(exp_order[3] == 1));
    repeat (4) tick();

    // Depth 2 against a 3-cycle slave: blocks after two grants
    lat2 = 3;
    tick(); c2.req = 1; c2.addr = 32'h104;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t3.core_gnt", 32'(c2.gnt), 32'(exp_g3[k]));
      chk("t3.mem_req", 32'(m2.req), 32'(exp_g3[k]));
      chk("t3.core_rvalid", 32'(c2.rvalid), 32'(exp_rv3[k]));
      tick();
    end
    c2.req = 0;
    repeat (5) tick();
    lat2 = 1;

    // Depth 1: aux write then core read with no bubble
    tick(); a1.req = 1; a1.we = 1; a1.addr = 32'h400; a1.wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t4.aux_gnt", 32'(a1.gnt), 1);
    tick(); a1.req = 0; a1.we = 0; c1.req = 1; c1.addr = 32'h400;
    @(negedge clk);
    chk("t4.core_gnt", 32'(c1.gnt), 1);
    chk("t4.mem_req", 32'(m1.req), 1);
    chk("t4.aux_rvalid", 32'(a1.rvalid), 1);
    tick(); c1.req = 0;
    @(negedge clk);
    chk("t4.core_rvalid", 32'(c1.rvalid), 1);
    chk("t4.core_rdata", c1.rdata, 32'h1234_5678);
    repeat (3) tick();

    // Depth 1 with a 2-cycle slave: full without rvalid blocks; err path
    lat1 = 2;
    tick(); c1.req = 1; c1.addr = 32'h1000_0000;
    @(negedge clk);
    chk("t4b.core_gnt0", 32'(c1.gnt), 1);
    tick();
    @(negedge clk);
    chk("t4b.core_gnt1", 32'(c1.gnt), 0);
    chk("t4b.mem_req1", 32'(m1.req), 0);
    tick();
    @(negedge clk);
    chk("t4b.core_rvalid", 32'(c1.rvalid), 1);
    chk("t4b.core_err", 32'(c1.err), 1);
    chk("t4b.core_gnt2", 32'(c1.gnt), 1);
    tick(); c1.req = 0;
    repeat (4) tick();

    // Orphan response on depth 2
    tick(); inj2 = 1'b1;
    @(negedge clk);
    chk("t5.core_rvalid", 32'(c2.rvalid), 0);
    chk("t5.aux_rvalid", 32'(a2.rvalid), 0);
    tick(); inj2 = 1'b0;
    @(negedge clk);
    chk("t5.orphan_set", 32'(orph2_o), 1);
    repeat (10) tick();
    @(negedge clk);
    chk("t5.orphan_sticky", 32'(orph2_o), 1);
    do_reset();
    @(negedge clk);
    chk("t5.orphan_cleared", 32'(orph2_o), 0);

    // Reset with one transaction outstanding; late rvalid becomes an orphan
    lat2 = 3;
    tick(); c2.req = 1; c2.addr = 32'h108;
    @(negedge clk);
    chk("t6.core_gnt", 32'(c2.gnt), 1);
    tick(); c2.req = 0; rst_n = 1'b0;
    @(negedge clk);
    chk("t6.rst_core_rvalid", 32'(c2.rvalid), 0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("t6.orphan_pre", 32'(orph2_o), 0);
    tick();
    @(negedge clk);
    chk("t6.late_core_rvalid", 32'(c2.rvalid), 0);
    chk("t6.late_aux_rvalid", 32'(a2.rvalid), 0);
    tick();
    @(negedge clk);
    chk("t6.orphan_set", 32'(orph2_o), 1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that merges the Ibex core data port and a secondary data master (debug/DMA loader) onto a single `ibex_data_bus` slave port. It sits directly upstream of the data RAM. It issues at most one request per cycle downstream and tracks outstanding transactions in an in-order ID FIFO. Each `rvalid`/`rdata`/`err` response is returned to the master that issued the matching request.

## Interface
- `MAX_OUTSTANDING`, default 2: depth of the ID FIFO, i.e. the number of granted transactions awaiting `rvalid`. Legal range is 1 to 4.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `core_bus`  `ibex_data_bus.slave`  interface: master 0, the Ibex core LSU (`req`, `gnt`, `rvalid`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`, `rdata[31:0]`, `rdata_intg[6:0]`, `err`).
- `aux_bus`  `ibex_data_bus.slave`  interface: master 1, the secondary master; same signal set.
- `mem_bus`  `ibex_data_bus.master`  interface: downstream slave (data RAM).
- `resp_orphan`  output  1: sticky flag, set when `mem_bus.rvalid` arrives while the ID FIFO is empty. Cleared only by reset.

## Operation
- **Arbitration** is combinational each cycle among the masters with `req`=1, provided the FIFO is not full (`count < MAX_OUTSTANDING`).
  - One master requesting: it is selected.
  - Both requesting: the winner is set by the policy in Configuration.
- **Forwarding:** `mem_bus.req` = a master is selected AND FIFO not full. `mem_bus.we`/`be`/`addr`/`wdata` are muxed from the selected master; they are driven from master 0 when nothing is selected.
- **Grant:** `gnt` to the selected master = `mem_bus.gnt`. The non-selected master sees `gnt`=0 and must hold its request stable (Ibex protocol).
- **Handshake:** a transfer occurs on `mem_bus.req && mem_bus.gnt`. On a handshake the selected master ID (1 bit) is pushed into the FIFO.
- **Response:**
  - When `mem_bus.rvalid`=1 and the FIFO is non-empty, the head ID is popped.
  - `rvalid` is asserted only to the master whose ID matches the head.
  - `rdata`, `rdata_intg` and `err` are broadcast to both masters; they are qualified by that master's own `rvalid`.
- **Simultaneous push and pop:** `count` is unchanged and the FIFO contents shift correctly. A pop is legal in the same cycle as a push.
- **Full FIFO:** `mem_bus.req` is held 0 and no `gnt` goes to any master. A pop in that cycle does not unblock the request until the next cycle (the full check uses the registered `count`).
- **Orphan response** (`rvalid` with an empty FIFO): no master receives `rvalid`, `resp_orphan` is set, and `count` stays 0.
- **Counts:** `count` is `$clog2(MAX_OUTSTANDING+1)` bits wide; read/write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Request path is combinational (master `req` to `mem_bus.req`, `mem_bus.gnt` to master `gnt`): zero added latency.
- Response path is combinational (`mem_bus.rvalid` to master `rvalid`). With the data RAM (gnt = req, rvalid one cycle later) a master sees `rvalid` exactly 1 cycle after its grant.
- Back-to-back: against a 1-cycle slave with `MAX_OUTSTANDING`≥1, one transfer per cycle is sustained. At `MAX_OUTSTANDING`=1 this relies on the pop and push occurring in the same cycle, so the request must be allowed when `count`=1 and `mem_bus.rvalid`=1. The full check is therefore `count == MAX_OUTSTANDING && !mem_bus.rvalid`. This overrides the Full FIFO rule above.
- Reset values:
  - FIFO empty, `count`=0, pointers 0.
  - `resp_orphan`=0, round-robin last-winner=1.
  - As a consequence, all master `rvalid` outputs are 0 during reset.
- Reset mid-operation: outstanding IDs are discarded. Any `rvalid` arriving after reset release with an empty FIFO is treated as an orphan.

## Configuration
- `DATA_BUS_ARB_ROUND_ROBIN_EN` defined: on a conflict the master that did not win the last handshake wins. The last-winner register is updated only on a handshake; it resets to 1, so master 0 wins the first conflict.
- Not defined: fixed priority, with master 0 (core) always winning a conflict. The last-winner register is not implemented.

## Test plan
- Single core read, addr 0x100, with RAM preloaded to 0xDEADBEEF: `core gnt` in cycle 0, `core rvalid`=1 with `rdata`=0xDEADBEEF in cycle 1, `aux rvalid` stays 0.
- Both masters request every cycle for 4 cycles:
  - Round-robin build: grant order core, aux, core, aux, with each `rvalid` routed to the matching master one cycle later.
  - Fixed-priority build: core granted 4 times, aux never.
- `MAX_OUTSTANDING`=2 with a slave stub that delays `rvalid` by 3 cycles: after 2 grants `mem_bus.req`=0 and no master gets `gnt` until the first `rvalid` pops.
- Simultaneous push/pop at `MAX_OUTSTANDING`=1 against the data RAM: aux write then core read on consecutive cycles; both granted without a bubble, and `count` never exceeds 1.
- Inject `mem_bus.rvalid`=1 with an empty FIFO: no master `rvalid`, `resp_orphan`=1 and still 1 ten cycles later, 0 after `rst_n` pulse.
- Assert `rst_n`=0 with one transaction outstanding: after release `count`=0, and a late `rvalid` sets `resp_orphan` with no master `rvalid`.
